// File: rtl/omem_spike_drain_if.sv
// NoC-side packet port and host-side result-read channels of the output-memory endpoint.
interface omem_spike_drain_if #(
  parameter int WIDTH_PACKAGE  = 50,
  parameter int WIDTH_addr     = 12,
  parameter int WIDTH_out_data = 13
);
  logic                      pkt_valid;
  logic                      pkt_ready;
  logic [WIDTH_PACKAGE-1:0]  pkt_data;
  logic                      start_valid;
  logic                      start_ready;
  logic                      hdr_valid;
  logic                      hdr_ready;
  logic [1:0]                hdr_ts;
  logic [1:0]                hdr_layer;
  logic                      spk_valid;
  logic                      spk_ready;
  logic [WIDTH_addr-1:0]     spk_addr;
  logic [WIDTH_out_data-1:0] spk_data;
  logic                      done_valid;
  logic                      done_ready;
  logic                      err_drop;

  modport slave (
    input  pkt_valid, pkt_data, start_ready, hdr_ready, spk_ready, done_ready,
    output pkt_ready, start_valid, hdr_valid, hdr_ts, hdr_layer,
           spk_valid, spk_addr, spk_data, done_valid, err_drop
  );

  modport master (
    output pkt_valid, pkt_data, start_ready, hdr_ready, spk_ready, done_ready,
    input  pkt_ready, start_valid, hdr_valid, hdr_ts, hdr_layer,
           spk_valid, spk_addr, spk_data, done_valid, err_drop
  );
endinterface

// File: rtl/omem_spike_drain.sv
// Output-memory NoC endpoint: collects one spike bitmap per timestep, then drains
// start / (header + spike stream) per timestep / done to the host.
module omem_spike_drain #(
  parameter int WIDTH_PACKAGE  = 50,
  parameter int ADDR_START     = 41,
  parameter int ADDR_END       = 38,
  parameter int OPCODE_START   = 37,
  parameter int OPCODE_END     = 32,
  parameter int DATA_START     = 31,
  parameter int DATA_END       = 0,
  parameter int PE_ID          = 12,
  parameter logic [OPCODE_START-OPCODE_END:0] OP_SPIKE = 6'd5,
  parameter int DEPTH_R        = 21,
  parameter int NUM_TS         = 2,
  parameter int LAYER          = 1,
  parameter int WIDTH_addr     = 12,
  parameter int WIDTH_out_data = 13
) (
  input  logic                clk,
  input  logic                rst_n,
  omem_spike_drain_if.slave   bus
);
  localparam int MAP_N = DEPTH_R * DEPTH_R;
  localparam int AW    = $clog2(MAP_N);
  localparam int CW    = $clog2(MAP_N + 1);
  localparam int TSW   = (NUM_TS > 1) ? $clog2(NUM_TS) : 1;
  localparam int DSTW  = ADDR_START - ADDR_END + 1;
  localparam int OPW   = OPCODE_START - OPCODE_END + 1;
  localparam int PLW   = DATA_START - DATA_END + 1;

  typedef enum logic [2:0] {S_COLLECT, S_START, S_HDR, S_STREAM, S_DONE} state_t;

  state_t                           r_state;
  logic [NUM_TS-1:0][MAP_N-1:0]     r_spk_map;
  logic [NUM_TS-1:0][MAP_N-1:0]     r_wr_map;
  logic [NUM_TS-1:0][CW-1:0]        r_cnt;
  logic                             r_start_valid, r_hdr_valid, r_spk_valid, r_done_valid;
  logic                             r_err_drop;
  logic [1:0]                       r_ts_idx;
  logic [WIDTH_addr-1:0]            r_rd_addr;
  logic                             r_spk_bit;

  // ---------------- packet decode ----------------
  logic [PLW-1:0]        w_payload;
  logic [DSTW-1:0]       w_dest;
  logic [OPW-1:0]        w_op;
  logic [1:0]            w_ts, w_ts_m1;
  logic [WIDTH_addr-1:0] w_addr;
  logic                  w_spike, w_bad, w_hs, w_we, w_drop, w_pkt_ready;
  logic [TSW-1:0]        w_tsi;
  logic [AW-1:0]         w_aidx;
  logic                  w_unused_bits;

  assign w_payload = bus.pkt_data[DATA_START:DATA_END];
  assign w_dest    = bus.pkt_data[ADDR_START:ADDR_END];
  assign w_op      = bus.pkt_data[OPCODE_START:OPCODE_END];
  assign w_ts      = w_payload[30:29];
  assign w_addr    = w_payload[28:17];
  assign w_spike   = w_payload[0];
  assign w_ts_m1   = w_ts - 2'd1;
  assign w_tsi     = w_ts_m1[TSW-1:0];
  assign w_aidx    = w_addr[AW-1:0];
  assign w_unused_bits = &{w_payload[31], w_payload[16:1],
                           bus.pkt_data[WIDTH_PACKAGE-1:ADDR_START+1], w_addr[WIDTH_addr-1:AW]};

  assign w_bad  = (w_dest != DSTW'(PE_ID)) || (w_op != OP_SPIKE) || (w_ts == 2'd0) ||
                  (w_ts > 2'(NUM_TS)) || (w_addr >= WIDTH_addr'(MAP_N));
  assign w_hs   = bus.pkt_valid && w_pkt_ready;
  assign w_we   = w_hs && !w_bad;
  assign w_drop = w_hs && w_bad;

  logic w_all_full;
  always_comb begin
    w_all_full = 1'b1;
    for (int t = 0; t < NUM_TS; t++)
      if (r_cnt[t] != CW'(MAP_N)) w_all_full = 1'b0;
  end

  // Ready drops as soon as the maps are complete, so no packet slips in before START.
  assign w_pkt_ready = (r_state == S_COLLECT) && !w_all_full;

  logic w_clr;
  assign w_clr = r_done_valid && bus.done_ready;

  // ---------------- spike / written maps ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_spk_map <= '0;
      r_wr_map  <= '0;
      r_cnt     <= '0;
    end else if (w_clr) begin
      r_spk_map <= '0;
      r_wr_map  <= '0;
      r_cnt     <= '0;
    end else if (w_we) begin
      r_spk_map[w_tsi][w_aidx] <= w_spike;
      if (!r_wr_map[w_tsi][w_aidx]) begin
        r_wr_map[w_tsi][w_aidx] <= 1'b1;
        r_cnt[w_tsi]            <= r_cnt[w_tsi] + CW'(1);
      end
    end
  end

  // ---------------- drain read path ----------------
  logic [1:0]     w_rd_ts_m1;
  logic [TSW-1:0] w_rd_tsi;
  logic [AW-1:0]  w_nxt_aidx;
  logic           w_nxt_bit, w_first_bit;

  assign w_rd_ts_m1  = r_ts_idx - 2'd1;
  assign w_rd_tsi    = w_rd_ts_m1[TSW-1:0];
  assign w_nxt_aidx  = r_rd_addr[AW-1:0] + AW'(1);
  assign w_nxt_bit   = r_spk_map[w_rd_tsi][w_nxt_aidx];
  assign w_first_bit = r_spk_map[w_rd_tsi][0];

  // ---------------- drain FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_COLLECT;
      r_start_valid <= 1'b0;
      r_hdr_valid   <= 1'b0;
      r_spk_valid   <= 1'b0;
      r_done_valid  <= 1'b0;
      r_err_drop    <= 1'b0;
      r_ts_idx      <= '0;
      r_rd_addr     <= '0;
      r_spk_bit     <= 1'b0;
    end else begin
      r_err_drop <= w_drop;
      unique case (r_state)
        S_COLLECT: if (w_all_full) begin
          r_start_valid <= 1'b1;
          r_state       <= S_START;
        end
        S_START: if (bus.start_ready) begin
          r_start_valid <= 1'b0;
          r_ts_idx      <= 2'd1;
          r_hdr_valid   <= 1'b1;
          r_state       <= S_HDR;
        end
        S_HDR: if (bus.hdr_ready) begin
          r_hdr_valid <= 1'b0;
          r_rd_addr   <= '0;
          r_spk_bit   <= w_first_bit;
          r_spk_valid <= 1'b1;
          r_state     <= S_STREAM;
        end
        S_STREAM: if (bus.spk_ready) begin
          if (r_rd_addr == WIDTH_addr'(MAP_N - 1)) begin
            r_spk_valid <= 1'b0;
            if (r_ts_idx < 2'(NUM_TS)) begin
              r_ts_idx    <= r_ts_idx + 2'd1;
              r_hdr_valid <= 1'b1;
              r_state     <= S_HDR;
            end else begin
              r_done_valid <= 1'b1;
              r_state      <= S_DONE;
            end
          end else begin
            r_rd_addr <= r_rd_addr + WIDTH_addr'(1);
            r_spk_bit <= w_nxt_bit;
          end
        end
        S_DONE: if (bus.done_ready) begin
          r_done_valid <= 1'b0;
          r_state      <= S_COLLECT;
        end
        default: r_state <= S_COLLECT;
      endcase
    end
  end

  assign bus.pkt_ready   = w_pkt_ready;
  assign bus.start_valid = r_start_valid;
  assign bus.hdr_valid   = r_hdr_valid;
  assign bus.hdr_ts      = r_ts_idx;
  assign bus.hdr_layer   = 2'(LAYER);
  assign bus.spk_valid   = r_spk_valid;
  assign bus.spk_addr    = r_rd_addr;
  assign bus.spk_data    = {{(WIDTH_out_data-1){1'b0}}, r_spk_bit};
  assign bus.done_valid  = r_done_valid;
  assign bus.err_drop    = r_err_drop;
endmodule

// File: tb/tb_omem_spike_drain.sv
// Scoreboard bench: packet stimulus feeds a map-level model that queues the expected
// host drain sequence; an independent monitor pops and compares every host handshake.
module tb_omem_spike_drain;
  localparam int MAP_N  = 441;
  localparam int NUM_TS = 2;
  localparam int LAYER  = 1;
  localparam int PE_ID  = 12;
  localparam int OP_SP  = 5;
  localparam int TOTAL  = NUM_TS * MAP_N;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  omem_spike_drain_if bus();
  omem_spike_drain dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {int kind; int a; int b;} exp_t;  // kind: 0 start, 1 hdr, 2 spike, 3 done
  exp_t sb[$];

  int n_checks = 0, n_fail = 0;
  int exp_drops = 0, obs_drops = 0;
  int busy_cycles = 0;
  int ready_mode = 0;
  int last_beat_addr = -1, cur_hdr_ts = 0;

  bit mspk [NUM_TS+1][MAP_N];
  bit mwr  [NUM_TS+1][MAP_N];
  int mcnt [NUM_TS+1];

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic void push_exp(input int k, input int a, input int b);
    exp_t e;
    e.kind = k; e.a = a; e.b = b;
    sb.push_back(e);
  endfunction

  function automatic void model_clear();
    for (int t = 0; t <= NUM_TS; t++) begin
      mcnt[t] = 0;
      for (int a = 0; a < MAP_N; a++) begin mspk[t][a] = 1'b0; mwr[t][a] = 1'b0; end
    end
  endfunction

  // Reference: a packet is a drop or a bitmap write; complete maps release the drain.
  function automatic void model_apply(input int dest, input int op, input int ts,
                                      input int addr, input int spike);
    bit full;
    if (dest != PE_ID || op != OP_SP || ts < 1 || ts > NUM_TS || addr >= MAP_N) begin
      exp_drops++;
      return;
    end
    mspk[ts][addr] = spike[0];
    if (!mwr[ts][addr]) begin mwr[ts][addr] = 1'b1; mcnt[ts]++; end
    full = 1'b1;
    for (int t = 1; t <= NUM_TS; t++) if (mcnt[t] != MAP_N) full = 1'b0;
    if (full) begin
      push_exp(0, 0, 0);
      for (int t = 1; t <= NUM_TS; t++) begin
        push_exp(1, t, LAYER);
        for (int a = 0; a < MAP_N; a++) push_exp(2, a, int'(mspk[t][a]));
      end
      push_exp(3, 0, 0);
      model_clear();
    end
  endfunction

  task automatic send(input int dest, input int op, input int ts, input int addr, input int spike);
    logic [63:0] r;
    logic [49:0] p;
    bit acc;
    int k;
    r = {$urandom(), $urandom()};
    p = r[49:0];
    p[41:38] = dest[3:0];
    p[37:32] = op[5:0];
    p[30:29] = ts[1:0];
    p[28:17] = addr[11:0];
    p[0]     = spike[0];
    bus.pkt_data  = p;
    bus.pkt_valid = 1'b1;
    acc = 1'b0; k = 0;
    while (!acc && k < 6000) begin
      @(negedge clk); acc = bus.pkt_ready;
      @(posedge clk); k++;
    end
    #1;
    bus.pkt_valid = 1'b0;
    if (!acc) chk("pkt_accept_timeout", 0, 1);
    else begin
      chk("accept_after_drain", sb.size(), 0);
      model_apply(dest, op, ts, addr, spike);
    end
  endtask

  task automatic send_bad();
    int a;
    a = $urandom_range(0, MAP_N - 1);
    case ($urandom_range(0, 3))
      0:       send(5, OP_SP, 1, a, 1);
      1:       send(PE_ID, OP_SP, 3, a, 1);
      2:       send(PE_ID, OP_SP, 1, MAP_N + $urandom_range(0, 3000), 1);
      default: send(PE_ID, 0, 2, a, 1);
    endcase
  endtask

  // pat 0: spike = addr[0]; 1: random; 2: random but ts1/addr7 written 1 then rewritten 0.
  task automatic fill_all(input int pat, input bit shuffle, input int pdup, input int pbad);
    int ord[];
    int idx, j, tmp, sp;
    ord = new[TOTAL];
    for (int i = 0; i < TOTAL; i++) ord[i] = i;
    if (shuffle)
      for (int i = TOTAL - 1; i > 0; i--) begin
        j = $urandom_range(0, i); tmp = ord[i]; ord[i] = ord[j]; ord[j] = tmp;
      end
    if (ord[TOTAL-1] == 7) begin ord[TOTAL-1] = ord[0]; ord[0] = 7; end
    for (int i = 0; i < TOTAL - 1; i++) begin
      if (pbad > 0 && $urandom_range(0, 99) < pbad) send_bad();
      if (pdup > 0 && i > 0 && $urandom_range(0, 99) < pdup) begin
        j = ord[$urandom_range(0, i - 1)];
        send(PE_ID, OP_SP, j / MAP_N + 1, j % MAP_N, $urandom_range(0, 1));
      end
      idx = ord[i];
      sp  = (pat == 0) ? (idx % MAP_N) % 2 : (pat == 2 && idx == 7) ? 1 : $urandom_range(0, 1);
      send(PE_ID, OP_SP, idx / MAP_N + 1, idx % MAP_N, sp);
    end
    if (pat == 2) send(PE_ID, OP_SP, 1, 7, 0);
    repeat (4) @(posedge clk);
    #1;
    chk("no_early_start", int'(bus.start_valid), 0);
    idx = ord[TOTAL-1];
    sp  = (pat == 0) ? (idx % MAP_N) % 2 : $urandom_range(0, 1);
    send(PE_ID, OP_SP, idx / MAP_N + 1, idx % MAP_N, sp);
  endtask

  task automatic wait_drain();
    int k;
    k = 0;
    while (sb.size() != 0 && k < 20000) begin @(posedge clk); k++; end
    chk("drain_complete", sb.size(), 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  // host-side ready generation
  initial begin
    bus.start_ready = 1'b1; bus.hdr_ready = 1'b1; bus.spk_ready = 1'b1; bus.done_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0: begin bus.start_ready = 1; bus.hdr_ready = 1; bus.spk_ready = 1; bus.done_ready = 1; end
        1: begin bus.start_ready = 1; bus.hdr_ready = 1; bus.spk_ready = ~bus.spk_ready; bus.done_ready = 1; end
        default: begin
          bus.start_ready = ($urandom_range(0, 3) != 0);
          bus.hdr_ready   = ($urandom_range(0, 3) != 0);
          bus.spk_ready   = ($urandom_range(0, 3) != 0);
          bus.done_ready  = ($urandom_range(0, 3) != 0);
        end
      endcase
    end
  end

  task automatic pop_cmp(input int kind, input int a, input int b);
    exp_t e;
    if (sb.size() == 0) chk("unexpected_output_kind", kind, -1);
    else begin
      e = sb.pop_front();
      chk("out_kind", kind, e.kind);
      chk("out_field_a", a, e.a);
      chk("out_field_b", b, e.b);
    end
  endtask

  // monitor
  bit s_spk = 0, s_hdr = 0;
  int s_addr = 0, s_data = 0, s_ts = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        s_spk = 0; s_hdr = 0;
      end else begin
        if (bus.err_drop) obs_drops++;
        if (bus.start_valid || bus.hdr_valid || bus.spk_valid || bus.done_valid) begin
          busy_cycles++;
          chk("pkt_ready_during_drain", int'(bus.pkt_ready), 0);
        end
        if (s_spk) begin
          chk("spk_hold_valid", int'(bus.spk_valid), 1);
          chk("spk_hold_addr", int'(bus.spk_addr), s_addr);
          chk("spk_hold_data", int'(bus.spk_data), s_data);
          s_spk = 0;
        end
        if (s_hdr) begin
          chk("hdr_hold_valid", int'(bus.hdr_valid), 1);
          chk("hdr_hold_ts", int'(bus.hdr_ts), s_ts);
          s_hdr = 0;
        end
        if (bus.spk_valid && !bus.spk_ready) begin
          s_spk = 1; s_addr = int'(bus.spk_addr); s_data = int'(bus.spk_data);
        end
        if (bus.hdr_valid && !bus.hdr_ready) begin s_hdr = 1; s_ts = int'(bus.hdr_ts); end
        if (bus.start_valid && bus.start_ready) pop_cmp(0, 0, 0);
        if (bus.hdr_valid && bus.hdr_ready) begin
          cur_hdr_ts = int'(bus.hdr_ts);
          pop_cmp(1, int'(bus.hdr_ts), int'(bus.hdr_layer));
        end
        if (bus.spk_valid && bus.spk_ready) begin
          last_beat_addr = int'(bus.spk_addr);
          pop_cmp(2, int'(bus.spk_addr), int'(bus.spk_data));
        end
        if (bus.done_valid && bus.done_ready) pop_cmp(3, 0, 0);
      end
    end
  end

  initial begin
    int k;
    bit reached;
    bus.pkt_valid = 1'b0;
    bus.pkt_data  = '0;
    model_clear();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_start_valid", int'(bus.start_valid), 0);
    chk("rst_hdr_valid",   int'(bus.hdr_valid), 0);
    chk("rst_spk_valid",   int'(bus.spk_valid), 0);
    chk("rst_done_valid",  int'(bus.done_valid), 0);
    chk("rst_err_drop",    int'(bus.err_drop), 0);
    chk("rst_hdr_ts",      int'(bus.hdr_ts), 0);
    chk("rst_spk_addr",    int'(bus.spk_addr), 0);
    chk("rst_spk_data",    int'(bus.spk_data), 0);
    chk("rst_pkt_ready",   int'(bus.pkt_ready), 1);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // malformed packets only
    send(5, OP_SP, 1, 0, 1);
    send(PE_ID, OP_SP, 3, 1, 1);
    send(PE_ID, OP_SP, 1, MAP_N, 1);
    send(PE_ID, 0, 1, 2, 1);
    repeat (4) @(posedge clk);
    #1;
    chk("drops_bad_pkts", obs_drops, exp_drops);
    chk("no_start_after_bad", int'(bus.start_valid), 0);

    // ordered fill, full-rate drain
    ready_mode = 0;
    busy_cycles = 0;
    fill_all(0, 0, 0, 0);
    wait_drain();
    chk("drain_cycles_full_rate", busy_cycles, 1 + NUM_TS * (1 + MAP_N) + 1);
    chk("pkt_ready_after_done", int'(bus.pkt_ready), 1);

    // toggling spike ready, shuffled fill with rewrites
    ready_mode = 1;
    fill_all(1, 1, 5, 0);
    wait_drain();

    // addr 7 overwrite, interleaved bad packets, random backpressure
    ready_mode = 2;
    fill_all(2, 1, 5, 3);
    wait_drain();
    chk("drops_mixed", obs_drops, exp_drops);

    // reset in the middle of the first stream
    last_beat_addr = -1;
    cur_hdr_ts = 0;
    fill_all(1, 1, 0, 0);
    k = 0;
    while (!(cur_hdr_ts == 1 && last_beat_addr >= 200) && k < 10000) begin @(negedge clk); k++; end
    reached = (cur_hdr_ts == 1 && last_beat_addr >= 200);
    chk("reached_beat_200", int'(reached), 1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_start_valid", int'(bus.start_valid), 0);
    chk("midrst_hdr_valid",   int'(bus.hdr_valid), 0);
    chk("midrst_spk_valid",   int'(bus.spk_valid), 0);
    chk("midrst_done_valid",  int'(bus.done_valid), 0);
    sb.delete();
    model_clear();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("pkt_ready_after_midrst", int'(bus.pkt_ready), 1);
    repeat (20) @(posedge clk);
    #1;
    chk("no_start_after_midrst", int'(bus.start_valid), 0);

    // refill, then hold a packet pending across the whole drain
    fill_all(1, 1, 3, 2);
    send(PE_ID, OP_SP, 1, 3, 1);
    wait_drain();
    repeat (3) @(posedge clk);
    #1;
    chk("drops_final", obs_drops, exp_drops);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
